// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared state encoding and width defaults for the pipeline stage controller
//
// Purpose : common types and constants imported by pipe_entry and pipe_stage_ctl.
// Contents: default field widths, stall counter width, the stage occupancy
//           enumeration and a saturating increment helper.
package pipe_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_CTRL_W = 3;
  localparam int STALL_W    = 16;

  // Occupancy of the stage: no entry, main entry only, main plus skid entry.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } pipe_state_e;

  // Counts up by one and sticks at all-ones instead of wrapping.
  function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
    return (&v) ? v : v + {{(STALL_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/pipe_entry.sv
// rtl/pipe_entry.sv - one storage entry (valid bit plus instruction fields)
//
// Purpose : holds one instruction for the pipeline stage controller.
// Ports   : clk, rst (async, active-high)
//           ld     - capture d_* and set valid
//           clr    - drop the entry and zero its fields (wins over ld)
//           d_ctrl/d_rd/d_alu/d_rt - incoming fields
//           valid, q_ctrl/q_rd/q_alu/q_rt - stored entry
module pipe_entry
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CTRL_W = DEF_CTRL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld,
  input  logic              clr,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [ADDR_W-1:0] d_rd,
  input  logic [DATA_W-1:0] d_alu,
  input  logic [DATA_W-1:0] d_rt,
  output logic              valid,
  output logic [CTRL_W-1:0] q_ctrl,
  output logic [ADDR_W-1:0] q_rd,
  output logic [DATA_W-1:0] q_alu,
  output logic [DATA_W-1:0] q_rt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid  <= 1'b0;
      q_ctrl <= '0;
      q_rd   <= '0;
      q_alu  <= '0;
      q_rt   <= '0;
    end else if (clr) begin
      valid  <= 1'b0;
      q_ctrl <= '0;
      q_rd   <= '0;
      q_alu  <= '0;
      q_rt   <= '0;
    end else if (ld) begin
      valid  <= 1'b1;
      q_ctrl <= d_ctrl;
      q_rd   <= d_rd;
      q_alu  <= d_alu;
      q_rt   <= d_rt;
    end
  end

endmodule

// File: rtl/pipe_stage_ctl.sv
// rtl/pipe_stage_ctl.sv - valid/ready pipeline register stage with optional skid entry
//
// Purpose : registers ctrl/rd/alu/rt between two pipeline stages with
//           valid/ready handshaking, flush, and a back-pressure counter.
// Params  : DATA_W, ADDR_W, CTRL_W field widths; SKID=1 registered-ready
//           two-entry mode, SKID=0 single entry with pass-through ready.
// Ports   : clk, rst (async, active-high)
//           in_valid/in_ready, in_ctrl/in_rd/in_alu/in_rt - upstream side
//           flush - drop everything held, and any same-cycle push
//           out_valid/out_ready, out_ctrl/out_rd/out_alu/out_rt - downstream side
//           stall_cnt - saturating count of cycles with out_valid && !out_ready
module pipe_stage_ctl
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CTRL_W = DEF_CTRL_W,
  parameter int SKID   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CTRL_W-1:0]  in_ctrl,
  input  logic [ADDR_W-1:0]  in_rd,
  input  logic [DATA_W-1:0]  in_alu,
  input  logic [DATA_W-1:0]  in_rt,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CTRL_W-1:0]  out_ctrl,
  output logic [ADDR_W-1:0]  out_rd,
  output logic [DATA_W-1:0]  out_alu,
  output logic [DATA_W-1:0]  out_rt,
  output logic [STALL_W-1:0] stall_cnt
);

  pipe_state_e state, state_n;

  logic push, pop;
  logic main_ld, main_clr, skid_ld, skid_clr;

  logic              main_valid, skid_valid;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_d_ctrl;
  logic [ADDR_W-1:0] main_rd, skid_rd, main_d_rd;
  logic [DATA_W-1:0] main_alu, skid_alu, main_d_alu;
  logic [DATA_W-1:0] main_rt, skid_rt, main_d_rt;

  assign push = in_valid && in_ready;
  assign pop  = main_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_EMPTY;
    else     state <= state_n;
  end

  always_comb begin
    state_n  = state;
    main_ld  = 1'b0;
    main_clr = 1'b0;
    skid_ld  = 1'b0;
    skid_clr = 1'b0;
    if (flush) begin
      state_n  = ST_EMPTY;
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (push) begin
            main_ld = 1'b1;
            state_n = ST_ONE;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            main_ld = 1'b1;
          end else if (pop) begin
            main_clr = 1'b1;
            state_n  = ST_EMPTY;
          end else if (push && (SKID != 0)) begin
            // Downstream is stalled but ready was already promised upstream:
            // park the arrival in the skid entry.
            skid_ld = 1'b1;
            state_n = ST_TWO;
          end
        end
        ST_TWO: begin
          if (pop) begin
            main_ld  = 1'b1;
            skid_clr = 1'b1;
            state_n  = ST_ONE;
          end
        end
        default: begin
          state_n  = ST_EMPTY;
          main_clr = 1'b1;
          skid_clr = 1'b1;
        end
      endcase
    end
  end

  // The main entry refills from the skid entry whenever it holds something
  // (only the TWO->ONE pop); otherwise it takes the upstream instruction.
  always_comb begin
    main_d_ctrl = in_ctrl;
    main_d_rd   = in_rd;
    main_d_alu  = in_alu;
    main_d_rt   = in_rt;
    if (skid_valid) begin
      main_d_ctrl = skid_ctrl;
      main_d_rd   = skid_rd;
      main_d_alu  = skid_alu;
      main_d_rt   = skid_rt;
    end
  end

  pipe_entry #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .CTRL_W (CTRL_W)
  ) u_main (
    .clk    (clk),
    .rst    (rst),
    .ld     (main_ld),
    .clr    (main_clr),
    .d_ctrl (main_d_ctrl),
    .d_rd   (main_d_rd),
    .d_alu  (main_d_alu),
    .d_rt   (main_d_rt),
    .valid  (main_valid),
    .q_ctrl (main_ctrl),
    .q_rd   (main_rd),
    .q_alu  (main_alu),
    .q_rt   (main_rt)
  );

  pipe_entry #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .CTRL_W (CTRL_W)
  ) u_skid (
    .clk    (clk),
    .rst    (rst),
    .ld     (skid_ld),
    .clr    (skid_clr),
    .d_ctrl (in_ctrl),
    .d_rd   (in_rd),
    .d_alu  (in_alu),
    .d_rt   (in_rt),
    .valid  (skid_valid),
    .q_ctrl (skid_ctrl),
    .q_rd   (skid_rd),
    .q_alu  (skid_alu),
    .q_rt   (skid_rt)
  );

  generate
    if (SKID != 0) begin : g_skid
      // Registered from the next state so in_ready never depends on out_ready
      // within the same cycle; the skid entry absorbs the one-cycle lag.
      logic in_ready_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) in_ready_q <= 1'b1;
        else     in_ready_q <= (state_n != ST_TWO);
      end
      assign in_ready = in_ready_q;
    end else begin : g_pass
      assign in_ready = out_ready || !main_valid;
    end
  endgenerate

  assign out_valid = main_valid;
  assign out_ctrl  = main_valid ? main_ctrl : '0;
  assign out_rd    = main_rd;
  assign out_alu   = main_alu;
  assign out_rt    = main_rt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          stall_cnt <= '0;
    else if (main_valid && !out_ready) stall_cnt <= sat_inc(stall_cnt);
  end

endmodule

// File: tb/tb_pipe_stage_ctl.sv
// tb/tb_pipe_stage_ctl.sv - directed self-checking bench for pipe_stage_ctl
module tb_pipe_stage_ctl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // a_* : SKID=1 instance, b_* : SKID=0 instance
  logic        a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready;
  logic [2:0]  a_in_ctrl, a_out_ctrl;
  logic [4:0]  a_in_rd, a_out_rd;
  logic [31:0] a_in_alu, a_in_rt, a_out_alu, a_out_rt;
  logic [15:0] a_stall_cnt;

  logic        b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready;
  logic [2:0]  b_in_ctrl, b_out_ctrl;
  logic [4:0]  b_in_rd, b_out_rd;
  logic [31:0] b_in_alu, b_in_rt, b_out_alu, b_out_rt;
  logic [15:0] b_stall_cnt;

  int vectors = 0;
  int miscompares = 0;
  int pops = 0;

  pipe_stage_ctl #(.DATA_W(32), .ADDR_W(5), .CTRL_W(3), .SKID(1)) dut_skid (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_ctrl(a_in_ctrl), .in_rd(a_in_rd), .in_alu(a_in_alu), .in_rt(a_in_rt),
    .flush(a_flush),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_ctrl(a_out_ctrl), .out_rd(a_out_rd), .out_alu(a_out_alu), .out_rt(a_out_rt),
    .stall_cnt(a_stall_cnt)
  );

  pipe_stage_ctl #(.DATA_W(32), .ADDR_W(5), .CTRL_W(3), .SKID(0)) dut_pass (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_ctrl(b_in_ctrl), .in_rd(b_in_rd), .in_alu(b_in_alu), .in_rt(b_in_rt),
    .flush(b_flush),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_ctrl(b_out_ctrl), .out_rd(b_out_rd), .out_alu(b_out_alu), .out_rt(b_out_rt),
    .stall_cnt(b_stall_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_drive(input logic v, input logic [2:0] c, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] rt);
    a_in_valid = v;
    a_in_ctrl  = c;
    a_in_rd    = rd;
    a_in_alu   = alu;
    a_in_rt    = rt;
  endtask

  initial begin
    rst = 1'b1;
    a_drive(1'b0, 3'b000, 5'd0, 32'h0, 32'h0);
    a_flush = 1'b0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_ctrl = 3'b000; b_in_rd = 5'd0; b_in_alu = 32'h0; b_in_rt = 32'h0;
    b_flush = 1'b0; b_out_ready = 1'b0;

    // reset values while rst is held
    #2;
    chk("rst_out_valid", a_out_valid, 1'b0);
    chk("rst_out_ctrl",  a_out_ctrl, 3'b000);
    chk("rst_fields",    {a_out_rd, a_out_alu, a_out_rt}, 69'h0);
    chk("rst_stall_cnt", a_stall_cnt, 16'h0);
    chk("rst_in_ready",  a_in_ready, 1'b1);
    chk("rst_in_ready_pass", b_in_ready, 1'b1);

    // single push accepted on the first edge after release
    @(negedge clk);
    rst = 1'b0;
    a_drive(1'b1, 3'b100, 5'd8, 32'h0000_0010, 32'h0000_0055);
    a_out_ready = 1'b1;
    tick();
    chk("single_out_valid", a_out_valid, 1'b1);
    chk("single_out_rd",    a_out_rd, 5'd8);
    chk("single_out_alu",   a_out_alu, 32'h10);
    chk("single_out_ctrl",  a_out_ctrl, 3'b100);
    chk("single_out_rt",    a_out_rt, 32'h55);
    a_drive(1'b0, 3'b000, 5'd0, 32'h0, 32'h0);
    tick();
    chk("single_pop_valid", a_out_valid, 1'b0);
    chk("bubble_ctrl_zero", a_out_ctrl, 3'b000);

    // back-pressure: A then B with downstream stalled
    a_out_ready = 1'b0;
    a_drive(1'b1, 3'b001, 5'd1, 32'h0000_00A1, 32'h0000_00B1);
    chk("bp_ready_empty", a_in_ready, 1'b1);
    tick();
    chk("bp_a_valid", a_out_valid, 1'b1);
    chk("bp_a_alu",   a_out_alu, 32'hA1);
    chk("bp_ready_one", a_in_ready, 1'b1);
    a_drive(1'b1, 3'b010, 5'd2, 32'h0000_00B2, 32'h0000_00C2);
    tick();
    chk("bp_ready_after_b", a_in_ready, 1'b0);
    chk("bp_hold_alu",      a_out_alu, 32'hA1);
    chk("bp_stall_1",       a_stall_cnt, 16'd1);
    a_drive(1'b0, 3'b000, 5'd0, 32'h0, 32'h0);
    tick();
    chk("bp_hold_fields", {a_out_ctrl, a_out_rd, a_out_alu, a_out_rt},
        {3'b001, 5'd1, 32'hA1, 32'hB1});
    chk("bp_still_full", a_in_ready, 1'b0);
    a_out_ready = 1'b1;
    tick();
    chk("bp_pop_b_fields", {a_out_valid, a_out_ctrl, a_out_rd, a_out_alu, a_out_rt},
        {1'b1, 3'b010, 5'd2, 32'hB2, 32'hC2});
    chk("bp_ready_reopen", a_in_ready, 1'b1);
    tick();
    chk("bp_drained", a_out_valid, 1'b0);
    chk("bp_stall_2", a_stall_cnt, 16'd2);

    // flush while TWO with upstream asserting valid
    a_out_ready = 1'b0;
    a_drive(1'b1, 3'b100, 5'd3, 32'h0000_0C03, 32'h0);
    tick();
    a_drive(1'b1, 3'b100, 5'd4, 32'h0000_0D04, 32'h0);
    tick();
    chk("fl_in_two", a_in_ready, 1'b0);
    a_flush = 1'b1;
    a_drive(1'b1, 3'b111, 5'd5, 32'h0000_0E05, 32'h0);
    tick();
    chk("fl_out_valid", a_out_valid, 1'b0);
    chk("fl_out_ctrl",  a_out_ctrl, 3'b000);
    chk("fl_in_ready",  a_in_ready, 1'b1);
    chk("fl_keeps_stall", a_stall_cnt, 16'd4);
    a_flush = 1'b0;
    a_drive(1'b0, 3'b000, 5'd0, 32'h0, 32'h0);
    a_out_ready = 1'b1;
    tick();
    chk("fl_push_absent", a_out_valid, 1'b0);
    // flush beats a real push in EMPTY
    a_flush = 1'b1;
    a_drive(1'b1, 3'b111, 5'd6, 32'h0000_0F06, 32'h0);
    tick();
    chk("fl_push_dropped", a_out_valid, 1'b0);
    a_flush = 1'b0;
    a_drive(1'b0, 3'b000, 5'd0, 32'h0, 32'h0);
    tick();
    chk("fl_push_dropped2", a_out_valid, 1'b0);

    // async reset between edges while in TWO
    a_out_ready = 1'b0;
    a_drive(1'b1, 3'b101, 5'd7, 32'h0000_1107, 32'h0000_2207);
    tick();
    a_drive(1'b1, 3'b110, 5'd9, 32'h0000_1109, 32'h0000_2209);
    tick();
    a_drive(1'b0, 3'b000, 5'd0, 32'h0, 32'h0);
    chk("ar_in_two", a_in_ready, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("ar_out_valid", a_out_valid, 1'b0);
    chk("ar_fields", {a_out_ctrl, a_out_rd, a_out_alu, a_out_rt}, 72'h0);
    chk("ar_stall", a_stall_cnt, 16'h0);
    chk("ar_in_ready", a_in_ready, 1'b1);
    #1 rst = 1'b0;
    a_drive(1'b1, 3'b100, 5'd10, 32'h0000_330A, 32'h0);
    a_out_ready = 1'b1;
    tick();
    chk("ar_new_push", {a_out_valid, a_out_alu}, {1'b1, 32'h330A});
    a_drive(1'b0, 3'b000, 5'd0, 32'h0, 32'h0);
    tick();
    chk("ar_old_discarded", a_out_valid, 1'b0);

    // SKID=0: combinational ready and back-to-back throughput
    b_out_ready = 1'b0;
    b_in_valid = 1'b1; b_in_ctrl = 3'b100; b_in_alu = 32'h77;
    #1;
    chk("p0_ready_empty", b_in_ready, 1'b1);
    tick();
    b_in_valid = 1'b0;
    #1;
    chk("p0_valid", b_out_valid, 1'b1);
    chk("p0_ready_stalled", b_in_ready, 1'b0);
    b_out_ready = 1'b1;
    #1;
    chk("p0_ready_comb", b_in_ready, 1'b1);
    for (int i = 0; i < 100; i++) begin
      b_in_valid = 1'b1;
      b_in_alu   = 32'(1000 + i);
      b_in_rd    = 5'(i);
      if (b_out_valid && b_out_ready && b_out_alu >= 32'd1000) pops++;
      tick();
      chk("p0_order", {b_out_valid, b_out_alu}, {1'b1, 32'(1000 + i)});
    end
    b_in_valid = 1'b0;
    if (b_out_valid && b_out_ready && b_out_alu >= 32'd1000) pops++;
    tick();
    chk("p0_drained", b_out_valid, 1'b0);
    chk("p0_pops", pops, 100);

    // stall counter saturation
    a_out_ready = 1'b0;
    a_drive(1'b1, 3'b011, 5'd9, 32'hCAFE_F00D, 32'h1234_5678);
    tick();
    a_drive(1'b0, 3'b000, 5'd0, 32'h0, 32'h0);
    chk("sat_start", a_stall_cnt, 16'd0);
    repeat (100) @(posedge clk);
    #1;
    chk("sat_100", a_stall_cnt, 16'd100);
    repeat (70000) @(posedge clk);
    #1;
    chk("sat_ffff", a_stall_cnt, 16'hFFFF);
    chk("sat_held", {a_out_valid, a_out_ctrl, a_out_rd, a_out_alu, a_out_rt},
        {1'b1, 3'b011, 5'd9, 32'hCAFE_F00D, 32'h1234_5678});
    repeat (10) @(posedge clk);
    #1;
    chk("sat_no_wrap", a_stall_cnt, 16'hFFFF);
    a_out_ready = 1'b1;
    tick();
    chk("sat_pop", a_out_valid, 1'b0);
    chk("sat_kept", a_stall_cnt, 16'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipe_stage_ctl.md
PIPE_STAGE_CTL -- requirements
Module: pipe_stage_ctl

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of ALU result and store-data fields.
REQ-002 SHALL have parameter ADDR_W, default 5, width of destination register address.
REQ-003 SHALL have parameter CTRL_W, default 3, width of control bundle; bit [2]=Reg_w, [1]=Mem_w, [0]=Mem_r at default.
REQ-004 SHALL have parameter SKID, default 1, where 1 is a registered-ready 2-entry skid mode and 0 is a 1-entry pass-ready mode.
REQ-005 SHALL have port clk, input, 1, sole clock, all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-007 SHALL have port in_valid, input, 1, upstream stage holds a valid instruction.
REQ-008 SHALL have port in_ready, output, 1, stage accepts the upstream instruction this cycle.
REQ-009 SHALL have port in_ctrl, input, CTRL_W, upstream control bundle.
REQ-010 SHALL have port in_rd, input, ADDR_W, upstream destination register.
REQ-011 SHALL have port in_alu, input, DATA_W, upstream ALU result.
REQ-012 SHALL have port in_rt, input, DATA_W, forwarded Rt store data.
REQ-013 SHALL have port flush, input, 1, kill all held instructions.
REQ-014 SHALL have port out_valid, output, 1, output fields hold a valid instruction.
REQ-015 SHALL have port out_ready, input, 1, downstream stage consumes the output this cycle.
REQ-016 SHALL have ports out_ctrl/out_rd/out_alu/out_rt, output, CTRL_W/ADDR_W/DATA_W/DATA_W, registered stage outputs.
REQ-017 SHALL have port stall_cnt, output, 16, saturating count of back-pressure cycles.

Function
REQ-018 SHALL perform a push when in_valid && in_ready, and a pop when out_valid && out_ready.
REQ-019 SHALL present a pushed instruction on the outputs at the rising edge after the push (1-cycle latency) when the main entry is empty or popping.
REQ-020 SHALL keep states EMPTY (no entry), ONE (main entry valid) and TWO (main+skid valid, SKID=1 only).
REQ-021 SHALL transition EMPTY->ONE on push; ONE->EMPTY on pop without push; ONE->ONE on push+pop or idle.
REQ-022 SHALL, with SKID=1, transition ONE->TWO on push without pop, storing the instruction in the skid entry.
REQ-023 SHALL transition TWO->ONE on pop, moving the skid entry into the main entry in the same edge.
REQ-024 SHALL, with SKID=1, drive in_ready as the registered value of !(state==TWO), with no combinational path from out_ready.
REQ-025 SHALL, with SKID=0, drive in_ready = out_ready || !out_valid combinationally.
REQ-026 SHALL hold all output fields stable while out_valid && !out_ready.
REQ-027 SHALL force out_ctrl to all-zero whenever out_valid=0, so bubbles never write registers or memory.
REQ-028 SHALL, on flush, go to EMPTY at the next edge; flush SHALL win over a simultaneous push, which is dropped.
REQ-029 SHALL increment stall_cnt each cycle with out_valid && !out_ready, saturating at 16'hFFFF; flush SHALL not clear it.
REQ-030 SHALL preserve instruction order; no instruction is duplicated or lost except by flush.

Reset
REQ-031 SHALL, while rst=1, immediately set state EMPTY, out_valid=0, out_ctrl=0, out_rd=0, out_alu=0, out_rt=0, stall_cnt=0, and in_ready=1.
REQ-032 SHALL discard any in-flight instruction held in either entry when rst asserts mid-operation.
REQ-033 SHALL accept a push on the first rising edge after rst deasserts.

Structure
REQ-034 SHALL place the state enumeration (EMPTY/ONE/TWO) and default width constants in shared package pipe_pkg.
REQ-035 SHALL implement each storage entry with one sub-module, pipe_entry, that holds a valid bit plus the ctrl/rd/alu/rt fields and has a load enable and a clear input.

Verification
REQ-036 SHALL cover single push: rst release, in_valid=1, in_ctrl=3'b100, in_rd=5'd8, in_alu=32'h0000_0010, out_ready=1 -> next cycle out_valid=1, out_rd=8, out_alu=0x10.
REQ-037 SHALL cover back-pressure: out_ready=0, push A then B -> in_ready=0 after B; out_ready=1 -> A then B popped in order, stall_cnt=2.
REQ-038 SHALL cover flush with push: state TWO, flush=1 with in_valid=1 -> next cycle out_valid=0, out_ctrl=0, in_ready=1, pushed instruction absent.
REQ-039 SHALL cover saturation: hold out_valid=1 with out_ready=0 for 70000 cycles -> stall_cnt=16'hFFFF and no wrap.
REQ-040 SHALL cover async reset mid-operation: rst pulse between edges while in state TWO -> outputs 0 immediately without waiting for clk.
REQ-041 SHALL cover SKID=0 mode: out_ready=0 with out_valid=1 -> in_ready=0 in the same cycle; 100 back-to-back pushes with out_ready=1 -> 100 pops, one per cycle.
